// File: rtl/render_line_buf.sv
// -----------------------------------------------------------------------------
// render_line_buf
//
// Ping-pong line buffer between a pixel renderer and the display scan-out.
// The renderer pushes pixels in raster order through a valid/ready handshake.
// Each completed line fills one of two line banks. The display side replays
// the oldest full bank while the timing generator sweeps an active line.
//
// Parameters
//   H_RES  active pixels per line; also the depth of each line bank
//   V_RES  active lines per frame; used only for the frame_done pulse
//   CORDW  width of the sx/sy screen coordinates
//
// Ports (all logic runs on the rising edge of clk_pix)
//   clk_pix     pixel clock
//   rst_pix     synchronous active-high reset
//   in_valid    renderer has a pixel
//   in_ready    a pixel can be accepted this cycle (the write bank is not full)
//   in_rgb      renderer pixel {r,g,b}, 4 bits each
//   sx, sy      display position from the timing generator (sy is unused)
//   de          display data enable, high in the active area
//   out_r/g/b   display colour, one clk_pix after the sx/de sample
//   out_de      de delayed to line up with out_r/g/b
//   frame_done  high in the cycle that accepts the last pixel of a frame
//   underflow   sticky; set when a line is shown without a full bank
// -----------------------------------------------------------------------------
module render_line_buf #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CORDW = 10
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_rgb,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  output logic [3:0]       out_r,
  output logic [3:0]       out_g,
  output logic [3:0]       out_b,
  output logic             out_de,
  output logic             frame_done,
  output logic             underflow
);

  localparam int AW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [AW-1:0]    X_LAST  = AW'(H_RES - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(V_RES - 1);
  localparam logic [CORDW-1:0] SX_LAST = CORDW'(H_RES - 1);

  // Line order comes purely from the bank ping-pong, so sy is not needed.
  logic unused_sy;
  assign unused_sy = ^sy;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    full_reg;
  logic [1:0]    full_next;
  logic          wr_bank_reg;
  logic          rd_bank_reg;
  logic [AW-1:0] wr_x_reg;
  logic [YW-1:0] wr_y_reg;
  logic          line_ok_reg;

  // Output pipeline
  logic          show_reg;     // pixel in the bank read register is to be shown
  logic          rd_sel_reg;   // bank that produced the read register contents
  logic          out_de_reg;
  logic          underflow_reg;

  // ---------------------------------------------------------------------------
  // Handshake and control decode
  // ---------------------------------------------------------------------------
  logic          accept;
  logic          wr_last_x;
  logic          line_ok_now;
  logic          rd_release;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    set_mask;
  logic [1:0]    clr_mask;
  logic [11:0]   bank_q [2];

  assign in_ready   = !full_reg[wr_bank_reg];
  assign accept     = in_valid && in_ready;
  assign wr_last_x  = accept && (wr_x_reg == X_LAST);
  assign frame_done = wr_last_x && (wr_y_reg == Y_LAST);

  // line_ok is latched at sx == 0, but the pixel at sx == 0 is read in that
  // same cycle. So the decision at sx == 0 comes straight from the full flag.
  assign line_ok_now = (sx == '0) ? full_reg[rd_bank_reg] : line_ok_reg;

  // Only a line that was actually displayed releases its bank. An underflowed
  // line leaves rd_bank where it is, so the next line retries the same bank.
  assign rd_release = de && (sx == SX_LAST) && line_ok_now;

  // Outside the active area sx can exceed the bank depth. Reads are gated
  // there, and the low address bits are only used while de is high.
  assign rd_en   = de;
  assign rd_addr = sx[AW-1:0];

  // ---------------------------------------------------------------------------
  // Line banks. Each bank is a simple dual-port RAM with a registered read.
  // The full flag of each bank is updated independently. A completed write
  // on one bank and a release of the other bank in the same cycle therefore
  // both take effect. The same bank can never be set and cleared together:
  // a set needs the bank not full, and a clear needs it full.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic BANK = 1'(gi);

      logic [11:0] mem [H_RES];
      logic [11:0] q_reg;

      assign set_mask[gi]  = wr_last_x && (wr_bank_reg == BANK);
      assign clr_mask[gi]  = rd_release && (rd_bank_reg == BANK);
      assign full_next[gi] = (full_reg[gi] && !clr_mask[gi]) || set_mask[gi];

      always_ff @(posedge clk_pix) begin
        if (accept && (wr_bank_reg == BANK)) begin
          mem[wr_x_reg] <= in_rgb;
        end
        if (rd_en) begin
          q_reg <= mem[rd_addr];
        end
      end

      assign bank_q[gi] = q_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write side, read side and output pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      full_reg      <= '0;
      wr_bank_reg   <= 1'b0;
      rd_bank_reg   <= 1'b0;
      wr_x_reg      <= '0;
      wr_y_reg      <= '0;
      line_ok_reg   <= 1'b0;
      show_reg      <= 1'b0;
      rd_sel_reg    <= 1'b0;
      out_de_reg    <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      full_reg <= full_next;

      // Write pointer: advance on every accepted pixel. Move to the other
      // bank when a line completes.
      if (accept) begin
        if (wr_x_reg == X_LAST) begin
          wr_x_reg    <= '0;
          wr_bank_reg <= !wr_bank_reg;
          if (wr_y_reg == Y_LAST) begin
            wr_y_reg <= '0;
          end else begin
            wr_y_reg <= wr_y_reg + YW'(1);
          end
        end else begin
          wr_x_reg <= wr_x_reg + AW'(1);
        end
      end

      // The line decision is taken once, at the first active pixel, and
      // held for the rest of the line. A bank that completes mid-line is
      // therefore not shown until the next line.
      if (de && (sx == '0)) begin
        line_ok_reg <= full_reg[rd_bank_reg];
      end

      if (rd_release) begin
        rd_bank_reg <= !rd_bank_reg;
      end

      show_reg   <= de && line_ok_now;
      rd_sel_reg <= rd_bank_reg;
      out_de_reg <= de;

      if (de && !line_ok_now) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  // The bank read registers are not reset. Blank pixels, underflowed lines
  // and the post-reset cycle are forced to black by the registered show flag.
  logic [11:0] pix_out;
  assign pix_out = show_reg ? bank_q[rd_sel_reg] : 12'h000;

  assign out_r     = pix_out[11:8];
  assign out_g     = pix_out[7:4];
  assign out_b     = pix_out[3:0];
  assign out_de    = out_de_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_render_line_buf.sv
// -----------------------------------------------------------------------------
// tb_render_line_buf
//
// Testbench for render_line_buf, using reduced line and frame sizes to keep
// runs short. Each cycle, the step task does two things. First, it compares
// the DUT outputs from the previous edge with the scoreboard entry pushed when
// that cycle's stimulus was driven. Second, it drives the next stimulus and
// updates a behavioural model of the buffer: a count of full lines plus a
// FIFO of accepted pixels.
// -----------------------------------------------------------------------------
module tb_render_line_buf;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int CW = 10;

  logic          clk_pix = 1'b0;
  logic          rst_pix;
  logic          in_valid;
  logic          in_ready;
  logic [11:0]   in_rgb;
  logic [CW-1:0] sx;
  logic [CW-1:0] sy;
  logic          de;
  logic [3:0]    out_r;
  logic [3:0]    out_g;
  logic [3:0]    out_b;
  logic          out_de;
  logic          frame_done;
  logic          underflow;

  always #5 clk_pix = ~clk_pix;

  render_line_buf #(
    .H_RES (H),
    .V_RES (V),
    .CORDW (CW)
  ) dut (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rgb     (in_rgb),
    .sx         (sx),
    .sy         (sy),
    .de         (de),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b),
    .out_de     (out_de),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  int checks   = 0;
  int failures = 0;

  // Model state
  int          lines_full;
  int          wr_x_m;
  int          wr_y_m;
  int          acc_total;
  int          fd_seen;
  int          line_no;
  int          wr_mode;      // 0 none, 1 always, 2 random, 3 only at sx==H-1
  bit          line_ok_m;
  bit          underflow_m;
  bit          armed;
  logic [11:0] next_rgb;
  logic [11:0] rgb_stride;
  logic [11:0] pix_q [$];    // accepted pixels, oldest first
  logic [12:0] exp_q [$];    // expected {out_de, rgb} per driven cycle

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit d, input int x);
    bit          v;
    bit          acc;
    bit          ok_now;
    bit          rel;
    bit          fd_exp;
    logic [11:0] px;
    logic [12:0] e;
    @(negedge clk_pix);
    if (armed) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("out_de", 32'(out_de), 32'(e[12]));
        check_val("out_rgb", 32'({out_r, out_g, out_b}), 32'(e[11:0]));
      end
      check_val("in_ready", 32'(in_ready), 32'(lines_full < 2));
      check_val("underflow", 32'(underflow), 32'(underflow_m));
    end
    v = !r && ((wr_mode == 1) ||
               (wr_mode == 2 && $urandom_range(0, 1) == 1) ||
               (wr_mode == 3 && d && x == H - 1));
    rst_pix  = r;
    in_valid = v;
    in_rgb   = next_rgb;
    de       = d;
    sx       = CW'(x);
    sy       = CW'(line_no % V);
    fd_exp   = 1'b0;
    if (r) begin
      lines_full  = 0;
      wr_x_m      = 0;
      wr_y_m      = 0;
      acc_total   = 0;
      line_ok_m   = 1'b0;
      underflow_m = 1'b0;
      pix_q.delete();
      exp_q.delete();
      exp_q.push_back(13'h0000);
      armed = 1'b1;
    end else begin
      acc    = v && (lines_full < 2);
      ok_now = (d && x == 0) ? (lines_full > 0) : line_ok_m;
      px     = 12'h000;
      if (d && ok_now) begin
        if (pix_q.size() > 0) px = pix_q.pop_front();
        else px = 12'hfff;
      end
      exp_q.push_back({d, px});
      if (d && !ok_now) underflow_m = 1'b1;
      if (d && x == 0) line_ok_m = (lines_full > 0);
      rel = d && (x == H - 1) && ok_now;
      if (acc) begin
        pix_q.push_back(next_rgb);
        acc_total++;
        next_rgb = next_rgb + rgb_stride;
        if (wr_x_m == H - 1) begin
          wr_x_m = 0;
          lines_full++;
          if (wr_y_m == V - 1) begin
            wr_y_m = 0;
            fd_exp = 1'b1;
          end else begin
            wr_y_m++;
          end
        end else begin
          wr_x_m++;
        end
      end
      if (rel) lines_full--;
    end
    #1;
    check_val("frame_done", 32'(frame_done), 32'(fd_exp));
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, H + 2);
  endtask

  task automatic disp_line();
    for (int x = 0; x < H + 4; x++) step(1'b0, x < H, x);
    $display("line %0d shown full_lines=%0d underflow=%0b", line_no, lines_full,
             underflow_m);
    line_no++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, H + 2);
    step(1'b0, 1'b0, H + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_pix    = 1'b1;
    in_valid   = 1'b0;
    in_rgb     = '0;
    sx         = '0;
    sy         = '0;
    de         = 1'b0;
    wr_mode    = 0;
    next_rgb   = 12'h000;
    rgb_stride = 12'h001;
    line_no    = 0;
    fd_seen    = 0;
    armed      = 1'b0;

    // Reset, then one bank filled with pixel = x and a single line shown.
    step(1'b1, 1'b0, H + 2);
    do_reset();
    wr_mode = 1;
    idle(H);
    wr_mode = 0;
    idle(2);
    disp_line();

    // Writer held valid with no display: both banks fill, then stall.
    // One displayed line releases a bank.
    rgb_stride = 12'h1a7;
    wr_mode = 1;
    idle(2 * H + 5);
    disp_line();
    wr_mode = 0;
    disp_line();

    // Display with nothing written: black line, sticky underflow. The next
    // filled line must still come from bank 0.
    do_reset();
    disp_line();
    disp_line();
    wr_mode = 1;
    idle(H);
    wr_mode = 0;
    disp_line();

    // Last write into bank 1 lands in the same cycle as bank 0 is released.
    do_reset();
    wr_mode = 1;
    idle(2 * H - 1);
    wr_mode = 3;
    disp_line();
    wr_mode = 0;
    disp_line();

    // Reset in the middle of a valid line; the next line underflows.
    do_reset();
    wr_mode = 1;
    idle(H);
    wr_mode = 0;
    for (int x = 0; x <= H / 2; x++) step(1'b0, 1'b1, x);
    step(1'b1, 1'b1, H / 2 + 1);
    idle(2);
    disp_line();

    // Stream two frames with random valid against a running display.
    do_reset();
    fd_seen    = 0;
    rgb_stride = 12'h035;
    wr_mode    = 2;
    n          = 0;
    while (acc_total < 2 * H * V && n < 60) begin
      disp_line();
      n++;
    end
    wr_mode = 0;
    idle(2);
    check_val("frame_stream_done", 32'(acc_total >= 2 * H * V), 32'd1);
    check_val("frame_count", 32'(fd_seen), 32'(acc_total / (H * V)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/render_line_buf.md
RENDER_LINE_BUF -- requirements
Module: render_line_buf

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line and depth of each line bank.
REQ-002 Parameter V_RES, default 480, active lines per frame.
REQ-003 Parameter CORDW, default 10, width of the screen coordinate inputs.
REQ-004 clk_pix  in  1  pixel clock; the block's one clock, all logic on its rising edge.
REQ-005 rst_pix  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  renderer pixel valid.
REQ-007 in_ready  out  1  block can accept a pixel this cycle.
REQ-008 in_rgb  in  12  renderer pixel, {r[3:0], g[3:0], b[3:0]}, raster order.
REQ-009 sx  in  CORDW  horizontal position from the display timing generator.
REQ-010 sy  in  CORDW  vertical position from the display timing generator.
REQ-011 de  in  1  data enable from the timing generator, high in the active area.
REQ-012 out_r, out_g, out_b  out  4 each  registered display colour.
REQ-013 out_de  out  1  de delayed to align with out_r/g/b.
REQ-014 frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.
REQ-015 underflow  out  1  sticky flag: a line was displayed without rendered data.

Function
REQ-016 Two line banks (0,1), each H_RES x 12 bits, each with a full flag; the write pointer wr_bank and the read pointer rd_bank each select one bank.
REQ-017 in_ready SHALL equal !full[wr_bank]; a pixel is accepted iff in_valid && in_ready.
REQ-018 An accepted pixel is written to bank wr_bank at address wr_x, and wr_x increments.
REQ-019 When the pixel accepted has wr_x == H_RES-1: set full[wr_bank], toggle wr_bank, reset wr_x to 0, and increment wr_y.
REQ-020 When that pixel also has wr_y == V_RES-1: wr_y wraps to 0 and frame_done pulses high for exactly that one cycle.
REQ-021 At de && sx == 0, latch line_ok = full[rd_bank].
REQ-022 For de && line_ok: read bank rd_bank at address sx; out_r/g/b present that pixel one clk_pix after the sx/de sample (latency 1).
REQ-023 For de && !line_ok: out_r/g/b = 0 for the whole line, and underflow is set.
REQ-024 For !de: out_r/g/b = 0.
REQ-025 out_de SHALL equal de registered once.
REQ-026 At de && sx == H_RES-1 && line_ok: clear full[rd_bank] and toggle rd_bank; an underflowed line does not toggle rd_bank.
REQ-027 A set on one bank and a clear on the other in the same cycle SHALL both take effect.
REQ-028 The write side SHALL never overwrite a full bank; when both banks are full, in_ready stays 0 until a release.
REQ-029 sy is informational only; line order follows the bank ping-pong, with no sy comparison.
REQ-030 underflow is cleared only by reset.

Reset
REQ-031 On rst_pix, the block SHALL set: full[1:0]=0, wr_bank=0, rd_bank=0, wr_x=0, wr_y=0, line_ok=0.
REQ-032 On rst_pix, the block SHALL set: out_r/g/b=0, out_de=0, frame_done=0, underflow=0, in_ready=1 on the cycle after reset.
REQ-033 Bank memory contents are not reset.
REQ-034 Reset asserted mid-line or mid-frame SHALL abandon all buffered data, with all state returning to the REQ-031 and REQ-032 values.

Verification
REQ-035 Fill bank 0 with 640 pixels where pixel = x mod 4096, then run an active line -> out_r/g/b match each x one cycle after its sx; full[0] clears at sx=639; rd_bank=1.
REQ-036 Hold in_valid=1 with no display activity -> exactly 1280 pixels accepted, then in_ready=0; one displayed line -> in_ready=1 the cycle after sx=639.
REQ-037 Start an active line with no data written -> the whole line is 0, underflow=1 and stays 1, and rd_bank is unchanged.
REQ-038 Stream 640*480 pixels -> frame_done high exactly once, on acceptance of the 307200th pixel, with wr_y back to 0.
REQ-039 Make the write completing bank 1 coincide with sx=639 releasing bank 0 -> full=2'b10 afterwards and no accepted pixel is lost.
REQ-040 Assert rst_pix at sx=300 of a valid line -> next cycle all outputs are 0 and in_ready=1, and the next line underflows unless refilled.
